// File: rtl/env_pkg.sv
// Shared envelope definitions: ADSR state encoding used by the envelope generator and its debug port.
package env_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/env_adsr_if.sv
// Control/data bundle around the envelope generator: note gate, phase rates, oscillator sample and envelope outputs.
interface env_adsr_if
    import env_pkg::*;
#(
    parameter int unsigned WIDTH = 24
);

    logic                  gate;
    logic [WIDTH-1:0]      attack_step;
    logic [WIDTH-1:0]      decay_step;
    logic [WIDTH-1:0]      sustain_level;
    logic [WIDTH-1:0]      release_step;
    logic [WIDTH-1:0]      in_sample;
    logic [WIDTH-1:0]      out;
    logic                  active;
    logic [STATE_W-1:0]    state;

    // Controller side drives note and rates; envelope side returns the shaped sample and status.
    modport master (
        output gate, attack_step, decay_step, sustain_level, release_step, in_sample,
        input  out, active, state
    );

    modport slave (
        input  gate, attack_step, decay_step, sustain_level, release_step, in_sample,
        output out, active, state
    );

endinterface

// File: rtl/env_scaler.sv
// Scales an unsigned sample by the envelope level; keeps the upper half of the full product, registered.
module env_scaler #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] r_prod;

    assign w_prod = PW'(sample) * PW'(level);

    // Truncating >> WIDTH: full scale level maps to just under unity gain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prod <= '0;
        end else begin
            r_prod <= w_prod[PW-1:WIDTH];
        end
    end

    assign product = r_prod;

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope generator: per-sample level FSM with saturating/clamped ramps feeding a registered scaler.
module env_adsr
    import env_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               gate,
    input  logic [WIDTH-1:0]   attack_step,
    input  logic [WIDTH-1:0]   decay_step,
    input  logic [WIDTH-1:0]   sustain_level,
    input  logic [WIDTH-1:0]   release_step,
    input  logic [WIDTH-1:0]   in_sample,
    output logic [WIDTH-1:0]   out,
    output logic               active,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned      XW  = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX = '1;

    env_state_t       r_state;
    env_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] w_level_nxt;
    logic [XW-1:0]    w_sum;
    logic [XW-1:0]    w_dec;
    logic [XW-1:0]    w_rel;

    // One extra bit so overflow/underflow is visible instead of wrapping.
    assign w_sum = XW'(r_level) + XW'(attack_step);
    assign w_dec = XW'(r_level) - XW'(decay_step);
    assign w_rel = XW'(r_level) - XW'(release_step);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_level <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
        end
    end

    // A zero step means "reach the phase target in one sample".
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        case (r_state)
            IDLE: begin
                w_level_nxt = '0;
                if (gate) w_state_nxt = ATTACK;
            end
            ATTACK: begin
                if (!gate) begin
                    w_state_nxt = RELEASE;
                end else if ((attack_step == '0) || (w_sum >= XW'(MAX))) begin
                    w_level_nxt = MAX;
                    w_state_nxt = DECAY;
                end else begin
                    w_level_nxt = w_sum[WIDTH-1:0];
                end
            end
            DECAY: begin
                if (!gate) begin
                    w_state_nxt = RELEASE;
                end else if ((r_level <= sustain_level) || (decay_step == '0) ||
                             w_dec[WIDTH] || (w_dec[WIDTH-1:0] <= sustain_level)) begin
                    w_level_nxt = sustain_level;
                    w_state_nxt = SUSTAIN;
                end else begin
                    w_level_nxt = w_dec[WIDTH-1:0];
                end
            end
            SUSTAIN: begin
                if (!gate) begin
                    w_state_nxt = RELEASE;
                end else begin
                    w_level_nxt = sustain_level;
                end
            end
            RELEASE: begin
                // Retrigger resumes attack from the current level, never from zero.
                if (gate) begin
                    w_state_nxt = ATTACK;
                end else if ((release_step == '0) || w_rel[WIDTH] || (w_rel[WIDTH-1:0] == '0)) begin
                    w_level_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_level_nxt = w_rel[WIDTH-1:0];
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_level_nxt = '0;
            end
        endcase
    end

    env_scaler #(
        .WIDTH (WIDTH)
    ) u_scaler (
        .clk     (clk),
        .rstn    (rstn),
        .sample  (in_sample),
        .level   (r_level),
        .product (out)
    );

    assign active = (r_state != IDLE);
    assign state  = r_state;

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr: walks every ADSR phase, zero-step jumps, retrigger and reset, checking state/active/out.
module tb_env_adsr;
    import env_pkg::*;

    localparam int unsigned W = 24;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] lvl_prev;

    env_adsr_if #(.WIDTH(W)) bus ();

    env_adsr #(.WIDTH(W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .gate          (bus.gate),
        .attack_step   (bus.attack_step),
        .decay_step    (bus.decay_step),
        .sustain_level (bus.sustain_level),
        .release_step  (bus.release_step),
        .in_sample     (bus.in_sample),
        .out           (bus.out),
        .active        (bus.active),
        .state         (bus.state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] scale(input logic [W-1:0] s, input logic [W-1:0] l);
        logic [2*W-1:0] p;
        p = {24'd0, s} * {24'd0, l};
        return p[2*W-1:W];
    endfunction

    // One sample: out must reflect the sample and level present before this edge.
    task automatic step(input env_state_t es, input logic [W-1:0] el, input string tag);
        logic [W-1:0] eo;
        eo = scale(bus.in_sample, lvl_prev);
        @(posedge clk);
        #1;
        check_eq({tag, "/state"},  32'(bus.state),  32'(es));
        check_eq({tag, "/active"}, 32'(bus.active), 32'(es != IDLE));
        check_eq({tag, "/out"},    32'(bus.out),    32'(eo));
        lvl_prev = el;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        lvl_prev = '0;
        rstn              = 1'b0;
        bus.gate          = 1'b1;
        bus.attack_step   = 24'h400000;
        bus.decay_step    = 24'h100000;
        bus.sustain_level = 24'hC00000;
        bus.release_step  = 24'h400000;
        bus.in_sample     = 24'hFFFFFF;

        // Held in reset with gate high: nothing moves.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst/state",  32'(bus.state),  32'(IDLE));
            check_eq("rst/active", 32'(bus.active), 32'd0);
            check_eq("rst/out",    32'(bus.out),    32'd0);
        end
        rstn = 1'b1;

        step(ATTACK,  24'h000000, "rel_rst");
        step(ATTACK,  24'h400000, "att1");
        step(ATTACK,  24'h800000, "att2");
        step(ATTACK,  24'hC00000, "att3");
        step(DECAY,   24'hFFFFFF, "att_sat");
        step(DECAY,   24'hEFFFFF, "dec1");
        step(DECAY,   24'hDFFFFF, "dec2");
        step(DECAY,   24'hCFFFFF, "dec3");
        step(SUSTAIN, 24'hC00000, "dec_clamp");
        step(SUSTAIN, 24'hC00000, "sus_hold");
        bus.sustain_level = 24'hA00000;
        step(SUSTAIN, 24'hA00000, "sus_live");
        bus.sustain_level = 24'hC00000;
        step(SUSTAIN, 24'hC00000, "sus_back");

        bus.gate = 1'b0;
        step(RELEASE, 24'hC00000, "rel_enter");
        step(RELEASE, 24'h800000, "rel1");
        step(RELEASE, 24'h400000, "rel2");
        step(IDLE,    24'h000000, "rel_idle");
        step(IDLE,    24'h000000, "idle_hold");

        // Gate drop mid-attack, then retrigger from the release level.
        bus.gate = 1'b1;
        step(ATTACK,  24'h000000, "att_b0");
        step(ATTACK,  24'h400000, "att_b1");
        step(ATTACK,  24'h800000, "att_b2");
        bus.gate = 1'b0;
        step(RELEASE, 24'h800000, "att_drop");
        bus.gate = 1'b1;
        step(ATTACK,  24'h800000, "retrig");
        step(ATTACK,  24'hC00000, "retrig_step");

        // Zero steps jump straight to each phase target.
        bus.attack_step = 24'h000000;
        step(DECAY,   24'hFFFFFF, "att_zero");
        bus.decay_step = 24'h000000;
        step(SUSTAIN, 24'hC00000, "dec_zero");
        bus.gate = 1'b0;
        bus.release_step = 24'h000000;
        step(RELEASE, 24'hC00000, "rel_zero_in");
        step(IDLE,    24'h000000, "rel_zero");

        // Hold level at half scale and check the scaler latency.
        bus.gate = 1'b1;
        bus.sustain_level = 24'h800000;
        step(ATTACK,  24'h000000, "half_a");
        step(DECAY,   24'hFFFFFF, "half_d");
        step(SUSTAIN, 24'h800000, "half_s");
        step(SUSTAIN, 24'h800000, "half_hold");
        check_eq("scale_full", 32'(bus.out), 32'h7FFFFF);
        bus.in_sample = 24'h123456;
        check_eq("scale_lat0", 32'(bus.out), 32'h7FFFFF);
        step(SUSTAIN, 24'h800000, "scale_in");
        check_eq("scale_lat1", 32'(bus.out), 32'h091A2B);

        // Reset mid-note: asynchronous abort, then attack restarts from zero.
        rstn = 1'b0;
        #1;
        check_eq("arst/state",  32'(bus.state),  32'(IDLE));
        check_eq("arst/active", 32'(bus.active), 32'd0);
        check_eq("arst/out",    32'(bus.out),    32'd0);
        @(posedge clk);
        #1;
        check_eq("arst_hold/state", 32'(bus.state), 32'(IDLE));
        rstn = 1'b1;
        lvl_prev = '0;
        bus.in_sample   = 24'hFFFFFF;
        bus.attack_step = 24'h400000;
        step(ATTACK, 24'h000000, "post_rst");
        step(ATTACK, 24'h400000, "post_rst1");
        step(ATTACK, 24'h800000, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
